// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter and the L1 cache miss engines.
// Holds the arbiter state encoding and the default line-address and line-data widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-cache, D-cache and off-chip memory line-port signals seen by the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the caches and memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);

  logic              I_mem_read;
  logic [ADDR_W-1:0] I_mem_addr;
  logic [LINE_W-1:0] I_mem_rdata;
  logic              I_mem_ready;

  logic              D_mem_read;
  logic              D_mem_write;
  logic [ADDR_W-1:0] D_mem_addr;
  logic [LINE_W-1:0] D_mem_wdata;
  logic [LINE_W-1:0] D_mem_rdata;
  logic              D_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  I_mem_read, I_mem_addr,
    input  D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    input  mem_rdata, mem_ready,
    output I_mem_rdata, I_mem_ready,
    output D_mem_rdata, D_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output I_mem_read, I_mem_addr,
    output D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    output mem_rdata, mem_ready,
    input  I_mem_rdata, I_mem_ready,
    input  D_mem_rdata, D_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_stat_counter.sv
// Wrapping statistics counter with an increment enable.
// It rolls over to zero after its all-ones value.
module arb_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single off-chip line-memory port between the I-cache and D-cache miss engines.
// One transaction at a time; D has priority, while I is guaranteed to win after MAX_SKIP lost conflicts.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int MAX_SKIP = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] cnt_i_grant,
  output logic [CNT_W-1:0] cnt_d_grant,
  output logic [CNT_W-1:0] cnt_conflict
);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              grant_i;
  logic              grant_d;
  logic              i_req;
  logic              d_req;
  logic              conflict;
  logic              done;
  logic [3:0]        skip_cnt;
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LINE_W-1:0] cmd_wdata;

  assign i_req    = bus.I_mem_read;
  assign d_req    = bus.D_mem_read | bus.D_mem_write;
  assign conflict = (state == IDLE) && i_req && d_req;
  assign done     = ((state == GRANT_I) || (state == GRANT_D)) && bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration happens only in IDLE, so the requester that just completed is masked by RELEASE.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (skip_cnt == 4'(MAX_SKIP)) grant_i = 1'b1;
          else                          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_next = GRANT_I;
        if (grant_d) state_next = GRANT_D;
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ready) state_next = RELEASE;
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Winner's command is frozen at grant time; a simultaneous read+write from D is taken as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant_i) begin
      cmd_read  <= 1'b1;
      cmd_write <= 1'b0;
      cmd_addr  <= bus.I_mem_addr;
    end else if (grant_d) begin
      cmd_read  <= ~bus.D_mem_write;
      cmd_write <= bus.D_mem_write;
      cmd_addr  <= bus.D_mem_addr;
      cmd_wdata <= bus.D_mem_wdata;
    end else if (done) begin
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= 4'd0;
    end else if (grant_i) begin
      skip_cnt <= 4'd0;
    end else if (grant_d && i_req && (skip_cnt < 4'(MAX_SKIP))) begin
      skip_cnt <= skip_cnt + 4'd1;
    end
  end

  assign bus.mem_read    = cmd_read;
  assign bus.mem_write   = cmd_write;
  assign bus.mem_addr    = cmd_addr;
  assign bus.mem_wdata   = cmd_wdata;
  assign bus.I_mem_ready = (state == GRANT_I) && bus.mem_ready;
  assign bus.D_mem_ready = (state == GRANT_D) && bus.mem_ready;
  assign bus.I_mem_rdata = bus.mem_rdata;
  assign bus.D_mem_rdata = bus.mem_rdata;

  arb_stat_counter #(.CNT_W(CNT_W)) u_cnt_i_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_i),
    .count (cnt_i_grant)
  );

  arb_stat_counter #(.CNT_W(CNT_W)) u_cnt_d_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant_d),
    .count (cnt_d_grant)
  );

  arb_stat_counter #(.CNT_W(CNT_W)) u_cnt_conflict (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (conflict),
    .count (cnt_conflict)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip line-memory port between the I-cache miss engine and the D-cache miss/write-back engine.
- Sits between both L1 caches and main memory, below the RISCV_Pipeline core.
- Sequences one memory transaction at a time, latching each granted command so memory sees stable signals.
- Applies D-side priority with a bounded anti-starvation rule for the I-side, and keeps arbitration statistics.

Parameters:
- ADDR_W, 28, line address width (word address without the 2 offset bits).
- LINE_W, 128, cache line width in bits.
- MAX_SKIP, 2, consecutive I-side losses tolerated before I wins a conflict (1..15).
- CNT_W, 16, width of the statistic counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- I_mem_read  in  1  I-cache line read request; held until I_mem_ready.
- I_mem_addr  in  ADDR_W  I-cache line address.
- I_mem_rdata  out  LINE_W  line data to the I-cache.
- I_mem_ready  out  1  one-cycle completion pulse to the I-cache.
- D_mem_read  in  1  D-cache line read request; held until D_mem_ready.
- D_mem_write  in  1  D-cache line write-back request; held until D_mem_ready.
- D_mem_addr  in  ADDR_W  D-cache line address.
- D_mem_wdata  in  LINE_W  D-cache write-back data.
- D_mem_rdata  out  LINE_W  line data to the D-cache.
- D_mem_ready  out  1  one-cycle completion pulse to the D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion pulse.
- cnt_i_grant  out  CNT_W  number of I-side grants.
- cnt_d_grant  out  CNT_W  number of D-side grants.
- cnt_conflict  out  CNT_W  number of IDLE cycles in which both sides requested.

Behaviour:
- Reset: asynchronous, active-low. State=IDLE.
  - mem_read, mem_write, mem_addr, mem_wdata = 0.
  - skip_cnt = 0 and all counters = 0.
  - Reset asserted mid-transaction aborts it; no ready pulse is ever produced for the aborted request.
- State machine:
  - States: IDLE, GRANT_I, GRANT_D, RELEASE.
  - IDLE with no request: stay in IDLE.
  - IDLE with only I_mem_read: go to GRANT_I.
  - IDLE with only a D request (D_mem_read|D_mem_write): go to GRANT_D.
  - IDLE with both requesting: I wins if skip_cnt==MAX_SKIP, otherwise D wins.
  - GRANT_x: hold until mem_ready=1, then go to RELEASE.
  - RELEASE: unconditional single cycle back to IDLE. It masks the stale request still visible in the completion cycle.
- Command latch:
  - On the IDLE->GRANT_x edge, register the winner's command: read/write, addr, and for D also wdata.
  - mem_* outputs are driven only from these registers.
  - mem_read/mem_write stay asserted through GRANT_x, including the mem_ready cycle, and are 0 in RELEASE and IDLE.
- D command encoding: D_mem_read and D_mem_write both high is illegal and is treated as a write.
- Response routing:
  - In GRANT_I, I_mem_ready = mem_ready (combinational).
  - In GRANT_D, D_mem_ready = mem_ready (combinational).
  - The non-owner's ready is always 0.
  - I_mem_rdata and D_mem_rdata are both wired to mem_rdata (broadcast); only the owner's ready qualifies it.
- Latency:
  - Request seen in IDLE at cycle t: memory strobe asserts at t+1.
  - mem_ready at cycle r: owner's ready pulses at r, and the next grant is at r+2 at the earliest.
- Starvation control (skip_cnt, 4 bits):
  - Increments when D wins a conflict, saturating at MAX_SKIP.
  - Clears whenever I is granted.
  - Unchanged when D is granted with no I request.
- Counters:
  - cnt_i_grant / cnt_d_grant increment on the IDLE->GRANT_x edge.
  - cnt_conflict increments on IDLE cycles with both sides requesting.
  - All counters wrap modulo 2^CNT_W.
- A D-cache write-back followed by its refill read consists of two separate transactions; an I grant between them is legal.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2, RELEASE=2'd3.
  - ADDR_W and LINE_W defaults, shared with the cache modules.
- Natural sub-module: arb_stat_counter, a CNT_W wrapping counter with an increment enable, instantiated three times.
- FSM, command latch and routing stay in the top level.

Test Plan:
- I-only read:
  - Stimulus: I_mem_read=1, I_mem_addr=28'h0000010 at cycle 1; memory returns mem_ready with rdata=128'hA5 at cycle 6.
  - Required: mem_read=1 and mem_addr=28'h10 on cycles 2..6; I_mem_ready=1 only at cycle 6, I_mem_rdata=128'hA5; D_mem_ready=0 throughout; cnt_i_grant=1.
- D write-back then refill:
  - Stimulus: D_mem_write, addr 28'h20, wdata 128'h5A; after completion, D_mem_read, addr 28'h40.
  - Required: first transaction has mem_write=1 with mem_wdata=128'h5A; mem_write=0 in the RELEASE cycle; the read starts two cycles after the first mem_ready; cnt_d_grant=2.
- Conflict priority and anti-starvation (MAX_SKIP=2):
  - Stimulus: I held continuously while D re-requests immediately after every completion.
  - Required: grant order D, D, I, D, D, I; skip_cnt is 0 after each I grant; cnt_conflict=6.
- Simultaneous request on the mem_ready cycle:
  - Stimulus: the D owner deasserts after ready while I asserts in that same cycle.
  - Required: I is not granted in RELEASE; GRANT_I follows one cycle later.
- Reset mid-transaction:
  - Stimulus: rst_n=0 during GRANT_D, before any mem_ready.
  - Required: mem_read=mem_write=0 immediately, state IDLE, all counters 0; after release, a fresh I request is granted normally.
- Illegal D encoding:
  - Stimulus: D_mem_read=D_mem_write=1.
  - Required: mem_write=1, mem_read=0.
